// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/data-access sequencer: picks the next fetch
// address, issues instruction/data request strobes and latches halt.
module pc_sequencer #(
  parameter int               WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] instr,
  input  logic [2:0]        PCsrc,
  input  logic              bne,
  input  logic              memread,
  input  logic              memwr,
  input  logic              halt,
  input  logic              zero,
  input  logic [WORD_W-1:0] rdat1,
  input  logic              ihit,
  input  logic              dhit,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] npc,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              halted
);

  // state   | meaning
  // FETCH   | instruction request outstanding, pc advances on ihit
  // MEM     | data access outstanding, next pc parked in npc_q until dhit
  // HALTED  | all requests idle, pc frozen until reset
  typedef enum logic [1:0] {FETCH, MEM, HALTED} state_t;

  state_t            state;
  logic [WORD_W-1:0] npc_q;
  logic [WORD_W-1:0] imm_ext;
  logic [WORD_W-1:0] jump_tgt;
  logic [WORD_W-1:0] next_pc;
  logic              take_branch;
  logic              unused_instr_hi;

  assign npc             = pc + 32'd4;
  assign imm_ext         = {{(WORD_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign jump_tgt        = {npc[WORD_W-1:WORD_W-4], instr[25:0], 2'b00};
  assign take_branch     = zero ^ bne;
  assign unused_instr_hi = ^instr[WORD_W-1:26];

  always_comb begin
    next_pc = npc;
    case (PCsrc)
      3'd1:    next_pc = take_branch ? (npc + imm_ext) : npc;
      3'd2:    next_pc = jump_tgt;
      3'd3:    next_pc = rdat1;
      default: next_pc = npc;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      npc_q   <= '0;
      halted  <= 1'b0;
      imemREN <= 1'b1;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            // halt wins over a load/store issued by the same instruction
            if (halt) begin
              state   <= HALTED;
              halted  <= 1'b1;
              imemREN <= 1'b0;
            end else if (memread || memwr) begin
              state   <= MEM;
              npc_q   <= next_pc;
              imemREN <= 1'b0;
              dmemREN <= memread;
              dmemWEN <= memwr;
            end else begin
              pc <= next_pc;
            end
          end
        end
        MEM: begin
          if (dhit) begin
            state   <= FETCH;
            pc      <= npc_q;
            imemREN <= 1'b1;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
          end
        end
        HALTED: begin
          imemREN <= 1'b0;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer of the control unit's decoded outputs. Owns the program counter, selects the next fetch address, and sequences instruction fetch versus data-memory access.
- Generates memory request strobes.
- Latches halt.
- Sits between the control unit/register file and the cache/memory request interface of the datapath.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, address/data width (fixed at 32; imm/jump field positions assume MIPS format)

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-high reset
instr  input  32  current instruction (imm16 = [15:0], jump index = [25:0])
PCsrc  input  3  next-PC select from control unit
bne  input  1  branch sense: 1 = branch on not-equal
memread  input  1  instruction is a load
memwr  input  1  instruction is a store
halt  input  1  instruction is HALT
zero  input  1  ALU zero flag
rdat1  input  32  register rs value (jump-register target)
ihit  input  1  instruction memory returned instr this cycle
dhit  input  1  data memory access completed this cycle
pc  output  32  current fetch address
npc  output  32  pc + 4, combinational (jal link value)
imemREN  output  1  instruction read request
dmemREN  output  1  data read request
dmemWEN  output  1  data write request
halted  output  1  sticky halt flag

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: pc = PC_INIT, state = FETCH, npc_q = 0, halted = 0, dmemREN = dmemWEN = 0, imemREN = 1.
- PCsrc encoding:
  - 0 = sequential: pc+4
  - 1 = branch: taken when (zero ^ bne); target = pc+4 + (sign-extended imm16 << 2); not taken → pc+4
  - 2 = jump: {npc[31:28], instr[25:0], 2'b00}
  - 3 = jump-register: rdat1
  - 4..7 reserved → pc+4
- All arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is allowed silently.
- FSM states: FETCH, MEM, HALTED.
- FETCH:
  - imemREN = 1; dmem strobes 0.
  - No ihit: hold.
  - ihit & halt: go to HALTED; pc unchanged; halted set next edge.
  - ihit & (memread | memwr): latch computed next PC into npc_q; go to MEM; pc held.
  - ihit otherwise: pc <= next PC; stay in FETCH (one instruction per ihit cycle).
  - halt has priority over memread/memwr.
  - dhit in FETCH is ignored.
- MEM:
  - imemREN = 0; dmemREN = memread and dmemWEN = memwr as registered at the ihit edge (captured, not live).
  - dhit: pc <= npc_q; strobes drop; return to FETCH.
  - No dhit: hold indefinitely.
  - ihit in MEM is ignored.
- HALTED: all request strobes 0; pc frozen; halted = 1; exits only on RST.
- Latency:
  - Non-memory instruction: pc updates on the edge where ihit = 1.
  - Load/store: pc updates on the dhit edge (earliest one cycle after ihit).
- RST asserted mid-MEM or in HALTED: outputs return to reset values immediately (asynchronous); an outstanding data request is abandoned.
- npc is always the current pc + 4, including in MEM and HALTED.

Test Plan:
- Reset, PC_INIT=0; ihit every cycle, PCsrc=0 → pc = 0, 4, 8, 12 on consecutive edges; imemREN = 1 throughout.
- pc=0x40, PCsrc=1, bne=0, zero=1, imm=0xFFFE, ihit → pc=0x3C. Same with zero=0 → pc=0x44. bne=1, zero=0 → pc=0x3C.
- pc=0x1000_0010, PCsrc=2, instr[25:0]=0x0000100 → pc=0x1000_0400. PCsrc=3, rdat1=0x0000_0ABC → pc=0x0000_0ABC.
- Load at pc=0x20 with ihit, then dhit after 3 cycles:
  - dmemREN high for exactly those 3 cycles plus the dhit cycle; pc stays 0x20 until the dhit edge, then becomes 0x24.
  - Live memread dropping during MEM does not change dmemREN.
- halt with memwr=1 and ihit → HALTED: halted=1, dmemWEN never asserts, pc frozen, later ihit/dhit have no effect. Assert RST → pc=PC_INIT, halted=0 asynchronously.
- RST pulse mid-MEM (store pending) → dmemWEN drops before the next clock edge; state FETCH, pc=PC_INIT.
